// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding, mode constants and helpers
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} spi_state_t;

  localparam int SPI_CPOL = 0;
  localparam int SPI_CPOL_IDLE_LEVEL = SPI_CPOL;
  localparam int SPI_CPHA = 0;

  // Counter width that holds 0..clk_div-1 without wrapping.
  function automatic int div_width(input int clk_div);
    return $clog2(clk_div) + 1;
  endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// rtl/spi_sck_tick.sv - half-period divider for sck with clear and one-cycle tick
module spi_sck_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = div_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Holds at LAST rather than wrapping; the owner clears it on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (en && (div_cnt != LAST)) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, one DATA_W-bit MSB-first frame per start
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

  spi_state_t        state;
  spi_state_t        state_next;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;

  assign tick_en  = (state == SETUP) || (state == HIGH) || (state == LOW);
  assign tick_clr = (state_next != state);

  spi_sck_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (tick) state_next = HIGH;
      HIGH:    if (tick) state_next = LOW;
      LOW:     if (tick) state_next = (bit_cnt == LAST_BIT) ? DONE : HIGH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output and shift register moves only on the edge that enters a state,
  // so all outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else if (state_next != state) begin
      case (state_next)
        SETUP: begin
          tx_sh   <= tx_data;
          bit_cnt <= '0;
          cs_n    <= 1'b0;
          busy    <= 1'b1;
          mosi    <= tx_data[DATA_W-1];
          sck     <= 1'b0;
        end
        HIGH: begin
          sck   <= 1'b1;
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
        end
        LOW: begin
          sck     <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          // The final fall leaves the LSB on mosi until DONE.
          if (bit_cnt != (LAST_BIT - 1'b1)) begin
            mosi  <= tx_sh[DATA_W-2];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          cs_n    <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_sh;
          mosi    <= 1'b0;
        end
        IDLE: begin
          done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master (CLK_DIV=2 and CLK_DIV=1)
module tb_spi_master;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic busy0, done0, sck0, mosi0, cs_n0, miso0;
  logic busy1, done1, sck1, mosi1, cs_n1, miso1;
  logic [7:0] rx0, rx1;

  logic use_slave = 1'b0;
  logic [7:0] slv_d = 8'h00, slv_q = 8'h00, slv_out = 8'h00;

  int n_assert = 0;
  int n_fail = 0;

  assign miso0 = use_slave ? slv_out[7] : mosi0;
  assign miso1 = mosi1;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(DW), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .tx_data(tx0), .busy(busy0),
    .done(done0), .rx_data(rx0), .sck(sck0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
  );

  spi_master #(.DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1), .busy(busy1),
    .done(done1), .rx_data(rx1), .sck(sck1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
  );

  // Mode-0 slave: reloads its output register while deselected, shifts on sck fall.
  always @(negedge sck0 or posedge cs_n0) begin
    if (cs_n0) slv_out = slv_d;
    else       slv_out = {slv_out[6:0], 1'b0};
  end
  always @(posedge sck0) begin
    if (!cs_n0) slv_q = {slv_q[6:0], mosi0};
  end

  // Frame-level model: a frame is k = 0 .. (2*DW+1)*div-1 busy cycles; half-period h = k/div.
  int         m_phase [2];
  int         m_k     [2];
  logic [7:0] m_tx    [2];
  logic [7:0] m_rsh   [2];
  logic [7:0] m_rx    [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0; m_k[i] = 0; m_rx[i] = 8'h00; m_rsh[i] = 8'h00; m_tx[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int d, len;
        logic st, mi;
        logic [7:0] td;
        d   = div_of(i);
        len = (2 * DW + 1) * d;
        st  = (i == 0) ? start0 : start1;
        td  = (i == 0) ? tx0 : tx1;
        mi  = (i == 0) ? miso0 : miso1;
        case (m_phase[i])
          0: if (st) begin m_phase[i] = 1; m_k[i] = 0; m_tx[i] = td; end
          1: begin
            if (m_k[i] + 1 == len) begin
              m_phase[i] = 2;
              m_rx[i] = m_rsh[i];
            end else begin
              if (((m_k[i] + 1) % d == 0) && ((((m_k[i] + 1) / d) % 2) == 1))
                m_rsh[i] = {m_rsh[i][6:0], mi};
              m_k[i] = m_k[i] + 1;
            end
          end
          default: m_phase[i] = 0;
        endcase
      end
    end
  end

  // {sck, cs_n, mosi, busy, done, rx_data}
  function automatic logic [12:0] m_exp(input int i);
    int h, b;
    logic [12:0] e;
    e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_rx[i]};
    if (m_phase[i] == 1) begin
      h = m_k[i] / div_of(i);
      b = h / 2;
      if (b > DW - 1) b = DW - 1;
      e = {h[0], 1'b0, m_tx[i][7-b], 1'b1, 1'b0, m_rx[i]};
    end else if (m_phase[i] == 2) begin
      e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, m_rx[i]};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        logic [12:0] act;
        act = (i == 0) ? {sck0, cs_n0, mosi0, busy0, done0, rx0}
                       : {sck1, cs_n1, mosi1, busy1, done1, rx1};
        n_assert++;
        if (act !== m_exp(i)) begin
          n_fail++;
          $display("FAIL model_cmp dut%0d t=%0t got %h want %h (sck,cs_n,mosi,busy,done,rx)",
                   i, $time, act, m_exp(i));
        end
      end
    end
  end

  // Per-frame measurements on dut0 and frame/gap run lengths on dut1.
  int busy_c0, done_c0, rises0, csfall0, csbad0;
  logic psck0 = 1'b0, pcs0 = 1'b1;
  int brun1, crun1;
  int bq1[$];
  int cq1[$];
  logic pb1 = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      busy_c0 += int'(busy0);
      done_c0 += int'(done0);
      if (sck0 && !psck0) rises0++;
      if (!cs_n0 && pcs0) csfall0++;
      if (busy0 && cs_n0) csbad0++;
      psck0 = sck0;
      pcs0  = cs_n0;
      if (busy1) brun1++;
      else if (pb1) begin bq1.push_back(brun1); brun1 = 0; end
      pb1 = busy1;
      if (cs_n1) crun1++;
      else if (crun1 != 0) begin cq1.push_back(crun1); crun1 = 0; end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_meas();
    busy_c0 = 0; done_c0 = 0; rises0 = 0; csfall0 = 0; csbad0 = 0;
  endtask

  task automatic frame0(input logic [7:0] d);
    @(negedge clk);
    tx0 = d;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int maxc);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("done0_timeout", int'(done0 === 1'b1), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd, bad;
    clr_meas();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_sck", int'(sck0), 0);
    check("rst_cs_n", int'(cs_n0), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_done_mosi", int'({done0, mosi0}), 0);
    check("rst_rx", int'(rx0), 0);

    // Loopback 0xA5 at CLK_DIV=2
    clr_meas();
    frame0(8'hA5);
    wait_done0(200);
    check("t1_rx", int'(rx0), 'hA5);
    check("t1_busy_len", busy_c0, 34);
    check("t1_done_len", done_c0, 1);
    check("t1_sck_rises", rises0, 8);
    check("t1_cs_n_high_in_busy", csbad0, 0);

    // Paired with a slave holding 0x3C
    use_slave = 1'b1;
    slv_d = 8'h3C;
    slv_out = 8'h3C;
    slv_q = 8'h00;
    clr_meas();
    frame0(8'hC3);
    wait_done0(200);
    check("t2_slave_q", int'(slv_q), 'hC3);
    check("t2_rx", int'(rx0), 'h3C);
    use_slave = 1'b0;

    // start pulsed again mid-frame is ignored
    clr_meas();
    frame0(8'h5A);
    repeat (10) @(negedge clk);
    tx0 = 8'hFF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(200);
    check("t3_rx", int'(rx0), 'h5A);
    check("t3_busy_len", busy_c0, 34);
    check("t3_cs_falls", csfall0, 1);
    check("t3_done_len", done_c0, 1);

    // Asynchronous reset after three sck rises
    clr_meas();
    frame0(8'h96);
    n = 0;
    while (rises0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_reached_3_rises", rises0, 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t4_sck", int'(sck0), 0);
    check("t4_cs_n", int'(cs_n0), 1);
    check("t4_busy", int'(busy0), 0);
    check("t4_rx", int'(rx0), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    clr_meas();
    frame0(8'h3C);
    wait_done0(200);
    check("t4_rx_after", int'(rx0), 'h3C);
    check("t4_busy_len_after", busy_c0, 34);
    check("t4_rises_after", rises0, 8);

    // CLK_DIV=1, start held high over two frames
    @(negedge clk);
    bq1.delete();
    cq1.delete();
    brun1 = 0;
    crun1 = 0;
    tx1 = 8'h01;
    start1 = 1'b1;
    n = 0;
    while (!busy1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tx1 = 8'h80;
    nd = 0;
    n = 0;
    while (nd < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (done1) begin
        nd++;
        if (nd == 2) start1 = 1'b0;
      end
    end
    start1 = 1'b0;
    check("t5_two_dones", nd, 2);
    repeat (3) @(negedge clk);
    check("t5_frames", bq1.size(), 2);
    check("t5_busy_len0", (bq1.size() > 0) ? bq1[0] : -1, 17);
    check("t5_busy_len1", (bq1.size() > 1) ? bq1[1] : -1, 17);
    check("t5_cs_gap", (cq1.size() > 1) ? cq1[1] : -1, 2);
    check("t5_rx_last", int'(rx1), 'h80);

    // Idle quiet period
    clr_meas();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sck0 || !cs_n0 || mosi0 || done0 || sck1 || !cs_n1 || mosi1 || done1) bad++;
    end
    check("t6_idle_outputs", bad, 0);
    check("t6_no_done", done_c0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
